fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_queue.sv | 169 ++++++++++++++++
 tb/tb_fetch_queue.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0]   PC_STEP  = 32'd4;
  localparam logic [INST_W-1:0] INST_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  // One queued instruction together with the address it was fetched from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at 32 bits.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction/PC storage for the fetch queue: circular buffer with occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [31:0]                push_inst,
  input  logic [31:0]                push_pc,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty_c,
  output logic [31:0]                head_inst_c,
  output logic [31:0]                head_pc_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty_c;
  // A pop in the same cycle frees the slot, so push-on-full is legal then.
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so idle outputs are deterministic.
  assign head_inst_c = empty_c ? '0 : mem[rd_ptr].inst;
  assign head_pc_c   = empty_c ? '0 : mem[rd_ptr].pc;

  // Pointer and occupancy bookkeeping; clear drops all entries at once.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observable through a non-empty head.
  always_ff @(posedge clk) begin
    if (rst && !clear && do_push) begin
      mem[wr_ptr] <= '{inst: push_inst, pc: push_pc};
    end
  end

  // Upstream credit accounting must make an unpaired push into a full queue impossible.
  always_ff @(posedge clk) begin
    if (rst && !clear) begin
      assert (!(push && full && !do_pop));
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential memory reads under a credit
// limit, queues returned instructions with their PCs for decode, and flushes
// in-flight responses on a redirect.
// Optional build macro FETCH_QUEUE_BYPASS_EN: a response arriving while the
// queue is empty is offered to decode in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       im_req,
  output logic [31:0]                im_addr,
  input  logic                       im_gnt,
  input  logic                       im_rvalid,
  input  logic [31:0]                im_rdata,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [31:0]                d_inst,
  output logic [31:0]                d_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_nxt;
  logic [31:0]      resp_pc;
  logic [31:0]      resp_pc_nxt;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_cnt_nxt;
  logic [CNT_W-1:0] drop_new;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic [31:0]      head_inst;
  logic [31:0]      head_pc;
  logic [SUM_W-1:0] in_flight;
  logic             credit_ok;
  logic             granted;
  logic             rsp_take;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             clear;

  // Every queued entry plus every outstanding request holds one credit.
  assign in_flight = SUM_W'(fifo_count) + SUM_W'(outstanding);
  assign credit_ok = (in_flight < SUM_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  // Same-cycle forwarding of a response straight to decode when nothing is queued.
  assign bypass = (state == ST_FETCH) && fifo_empty && !redirect_valid && im_rvalid;
`else
  assign bypass = 1'b0;
`endif

  // A forwarded beat that decode takes immediately never enters the queue.
  assign push    = rsp_take && !(bypass && d_ready);
  assign d_valid = (!fifo_empty || bypass) && !redirect_valid;
  assign pop     = d_valid && d_ready && !fifo_empty;
  assign d_inst  = bypass ? im_rdata : head_inst;
  assign d_pc    = bypass ? resp_pc  : head_pc;
  assign im_addr = fetch_pc;
  assign q_count = fifo_count;

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
    end
  end

  // Next-state, request issue, response acceptance and drop accounting.
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    resp_pc_nxt     = resp_pc;
    outstanding_nxt = outstanding;
    drop_cnt_nxt    = drop_cnt;
    drop_new        = '0;
    im_req          = 1'b0;
    granted         = 1'b0;
    rsp_take        = 1'b0;
    clear           = 1'b0;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          resp_pc_nxt  = redirect_pc;
        end
      end

      ST_FETCH: begin
        if (redirect_valid) begin
          // A beat returning now is discarded here; a grant seen alongside the
          // redirect is still owed a response and must be dropped later.
          clear           = 1'b1;
          drop_new        = outstanding - CNT_W'(im_rvalid)
                            + CNT_W'(credit_ok && im_gnt);
          fetch_pc_nxt    = redirect_pc;
          resp_pc_nxt     = redirect_pc;
          outstanding_nxt = '0;
          drop_cnt_nxt    = drop_new;
          state_nxt       = (drop_new == '0) ? ST_FETCH : ST_FLUSH;
        end else begin
          im_req   = credit_ok;
          granted  = credit_ok && im_gnt;
          rsp_take = im_rvalid;
          if (granted)  fetch_pc_nxt = next_pc(fetch_pc);
          if (rsp_take) resp_pc_nxt  = next_pc(resp_pc);
          outstanding_nxt = outstanding + CNT_W'(granted) - CNT_W'(rsp_take);
        end
      end

      ST_FLUSH: begin
        if (redirect_valid) fetch_pc_nxt = redirect_pc;
        if (im_rvalid && (drop_cnt != '0)) drop_cnt_nxt = drop_cnt - CNT_W'(1);
        // Last stale beat gone: resume from the most recent redirect target.
        if (drop_cnt_nxt == '0) begin
          state_nxt   = ST_FETCH;
          resp_pc_nxt = fetch_pc_nxt;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .push        (push),
    .push_inst   (im_rdata),
    .push_pc     (resp_pc),
    .pop         (pop),
    .count       (fifo_count),
    .empty_c     (fifo_empty),
    .head_inst_c (head_inst),
    .head_pc_c   (head_pc)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a 1-cycle in-order memory model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             im_req;
  logic [31:0]      im_addr;
  logic             im_gnt;
  logic             im_rvalid;
  logic [31:0]      im_rdata;
  logic             d_valid;
  logic             d_ready;
  logic [31:0]      d_inst;
  logic [31:0]      d_pc;
  logic [CNT_W-1:0] q_count;

  logic        mem_hold;
  logic        force_accept;
  logic [31:0] pend[$];

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_gnt         (im_gnt),
    .im_rvalid      (im_rvalid),
    .im_rdata       (im_rdata),
    .d_valid        (d_valid),
    .d_ready        (d_ready),
    .d_inst         (d_inst),
    .d_pc           (d_pc),
    .q_count        (q_count)
  );

  always #5 clk = ~clk;

  // Memory content: address 0 holds 0x00500093.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h00500093;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory accept side: record accepted addresses mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && im_gnt && (im_req || force_accept)) pend.push_back(im_addr);
    end
  end

  // Memory return side: answer one cycle after acceptance, in order.
  initial begin
    im_rvalid = 1'b0;
    im_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_hold && pend.size() > 0) begin
        im_rvalid = 1'b1;
        im_rdata  = mem_word(pend.pop_front());
      end else begin
        im_rvalid = 1'b0;
        im_rdata  = '0;
      end
    end
  end

  task automatic do_reset(input bit chk);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    im_gnt         = 1'b0;
    d_ready        = 1'b0;
    mem_hold       = 1'b0;
    force_accept   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pend.delete();
    @(negedge clk);
    if (chk) begin
      check("rst_state",   32'(dut.state), 32'(ST_IDLE));
      check("rst_im_req",  32'(im_req), 32'd0);
      check("rst_im_addr", im_addr, 32'h0);
      check("rst_d_valid", 32'(d_valid), 32'd0);
      check("rst_d_inst",  d_inst, 32'h0);
      check("rst_d_pc",    d_pc, 32'h0);
      check("rst_q_count", 32'(q_count), 32'd0);
    end
    tick();
    rst = 1'b1;
  endtask

  // Wait for the first im_req and first d_valid, recording address/pc/inst.
  task automatic watch_first(input int budget, output logic [31:0] req_addr,
                             output logic [31:0] dv_pc, output logic [31:0] dv_inst,
                             output int flush_beats);
    bit got_req;
    bit got_dv;
    got_req     = 1'b0;
    got_dv      = 1'b0;
    req_addr    = 32'hDEAD_BEEF;
    dv_pc       = 32'hDEAD_BEEF;
    dv_inst     = 32'hDEAD_BEEF;
    flush_beats = 0;
    for (int i = 0; i < budget && !got_dv; i++) begin
      @(negedge clk);
      if (im_rvalid && dut.state == ST_FLUSH) flush_beats++;
      if (im_req && !got_req) begin
        got_req  = 1'b1;
        req_addr = im_addr;
      end
      if (d_valid && !got_dv) begin
        got_dv  = 1'b1;
        dv_pc   = d_pc;
        dv_inst = d_inst;
      end
    end
  endtask

  initial begin
    logic [31:0] addrs [8];
    int          n_addr;
    int          first_dv;
    int          n_gnt;
    int          beats;
    logic [31:0] ra;
    logic [31:0] pa;
    logic [31:0] ia;

    #1;
    // Reset values and start-up fetch stream with gnt tied high.
    do_reset(1'b1);
    im_gnt   = 1'b1;
    d_ready  = 1'b1;
    n_addr   = 0;
    first_dv = -1;
    @(negedge clk);
    check("a_idle_req", 32'(im_req), 32'd0);
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      if (im_req && im_gnt) begin
        addrs[n_addr] = im_addr;
        n_addr++;
      end
      if (d_valid && first_dv < 0) begin
        first_dv = j;
        check("a_first_pc",   d_pc, 32'h0);
        check("a_first_inst", d_inst, 32'h00500093);
      end
    end
    check("a_n_req",   32'(n_addr), 32'd7);
    check("a_addr0",   addrs[0], 32'h0);
    check("a_addr1",   addrs[1], 32'h4);
    check("a_addr2",   addrs[2], 32'h8);
`ifdef FETCH_QUEUE_BYPASS_EN
    check("a_first_dv", 32'(first_dv), 32'd2);
`else
    check("a_first_dv", 32'(first_dv), 32'd3);
`endif

    // Decode stalled: credit limit stops requests at DEPTH.
    do_reset(1'b0);
    im_gnt  = 1'b1;
    d_ready = 1'b0;
    n_gnt   = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (im_req && im_gnt) n_gnt++;
    end
    check("b_grants",  32'(n_gnt), 32'd4);
    check("b_q_count", 32'(q_count), 32'd4);
    check("b_req_low", 32'(im_req), 32'd0);
    tick();
    d_ready = 1'b1;
    @(negedge clk);
    check("b_pop_dv",  32'(d_valid), 32'd1);
    check("b_pop_pc",  d_pc, 32'h0);
    check("b_pop_req", 32'(im_req), 32'd0);
    tick();
    d_ready = 1'b0;
    @(negedge clk);
    check("b_after_req",  32'(im_req), 32'd1);
    check("b_after_addr", im_addr, 32'h10);
    check("b_after_cnt",  32'(q_count), 32'd3);

    // Redirect with three requests outstanding.
    do_reset(1'b0);
    mem_hold = 1'b1;
    tick();
    tick();
    im_gnt = 1'b1;
    repeat (3) tick();
    im_gnt         = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check("c_redir_req", 32'(im_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("c_state", 32'(dut.state), 32'(ST_FLUSH));
    check("c_drop",  32'(dut.drop_cnt), 32'd3);
    mem_hold = 1'b0;
    im_gnt   = 1'b1;
    d_ready  = 1'b1;
    watch_first(20, ra, pa, ia, beats);
    check("c_dropped",   32'(beats), 32'd3);
    check("c_next_addr", ra, 32'h100);
    check("c_first_pc",  pa, 32'h100);
    check("c_first_inst", ia, mem_word(32'h100));

    // Redirect coinciding with a grant and with decode ready.
    do_reset(1'b0);
    tick();
    tick();
    im_gnt = 1'b1;
    tick();
    im_gnt = 1'b0;
    tick();
    tick();
    check("d_pre_cnt", 32'(q_count), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    im_gnt         = 1'b1;
    d_ready        = 1'b1;
    force_accept   = 1'b1;
    @(negedge clk);
    check("d_redir_dv", 32'(d_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    force_accept   = 1'b0;
    check("d_state", 32'(dut.state), 32'(ST_FLUSH));
    check("d_drop",  32'(dut.drop_cnt), 32'd1);
    check("d_cnt",   32'(q_count), 32'd0);
    watch_first(20, ra, pa, ia, beats);
    check("d_dropped",  32'(beats), 32'd1);
    check("d_next_addr", ra, 32'h200);
    check("d_first_pc", pa, 32'h200);

    // Redirect to the top of the address space with nothing outstanding.
    do_reset(1'b0);
    d_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    im_gnt         = 1'b1;
    check("e_state", 32'(dut.state), 32'(ST_FETCH));
    @(negedge clk);
    check("e_addr0", im_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("e_addr1", im_addr, 32'h0);
    watch_first(10, ra, pa, ia, beats);
    check("e_first_pc", pa, 32'hFFFF_FFFC);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty-queue forwarding: response seen by decode in its arrival cycle.
    do_reset(1'b0);
    d_ready = 1'b1;
    tick();
    tick();
    im_gnt = 1'b1;
    tick();
    im_gnt = 1'b0;
    @(negedge clk);
    check("f_rvalid",  32'(im_rvalid), 32'd1);
    check("f_dv",      32'(d_valid), 32'd1);
    check("f_inst",    d_inst, 32'h00500093);
    check("f_pc",      d_pc, 32'h0);
    tick();
    @(negedge clk);
    check("f_q_count", 32'(q_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
